cordic_vectoring: RTL and testbench



---
 rtl/cordic_pkg.sv | 30 +++
 rtl/cordic_vec_stage.sv | 35 +++
 rtl/cordic_vectoring.sv | 146 ++++++++++++++
 tb/tb_cordic_vectoring.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cordic_pkg.sv
// cordic_pkg: constants, arctangent table and FSM state type shared by the CORDIC subsystem.
// Angles are signed Q3.29 radians; INV_K is the Q1.31 reciprocal of the CORDIC gain.
package cordic_pkg;

  localparam int ATAN_LEN = 30;

  localparam logic signed [31:0] PI_Q329      = 32'sd1686629713;
  localparam logic signed [31:0] HALF_PI_Q329 = 32'sd843314857;
  localparam logic [31:0]        INV_K        = 32'h4DBA76D4;

  // round(atan(2^-i) * 2^29)
  localparam logic signed [31:0] ATAN [ATAN_LEN] = '{
    32'sd421657428, 32'sd248918915, 32'sd131521918, 32'sd66762579,
    32'sd33510843,  32'sd16771758,  32'sd8387925,   32'sd4194219,
    32'sd2097141,   32'sd1048575,   32'sd524288,    32'sd262144,
    32'sd131072,    32'sd65536,     32'sd32768,     32'sd16384,
    32'sd8192,      32'sd4096,      32'sd2048,      32'sd1024,
    32'sd512,       32'sd256,       32'sd128,       32'sd64,
    32'sd32,        32'sd16,        32'sd8,         32'sd4,
    32'sd2,         32'sd1
  };

  typedef enum logic [1:0] {
    S_IDLE,
    S_ITERATE,
    S_SCALE,
    S_DONE
  } state_t;

endpackage

// File: rtl/cordic_vec_stage.sv
// cordic_vec_stage: one combinational vectoring micro-rotation that steers y toward zero.
// Shifts are arithmetic; all three outputs are computed from the old (x, y, z).
module cordic_vec_stage
  import cordic_pkg::*;
#(
  parameter int W = 34
) (
  input  logic signed [W-1:0] x,
  input  logic signed [W-1:0] y,
  input  logic signed [31:0]  z,
  input  logic [4:0]          i,
  input  logic signed [31:0]  atan_i,
  output logic signed [W-1:0] x_next,
  output logic signed [W-1:0] y_next,
  output logic signed [31:0]  z_next
);

  logic signed [W-1:0] x_sh;
  logic signed [W-1:0] y_sh;

  always_comb begin
    x_sh = x >>> i;
    y_sh = y >>> i;
    if (y[W-1]) begin
      x_next = x - y_sh;
      y_next = y + x_sh;
      z_next = z - atan_i;
    end else begin
      x_next = x + y_sh;
      y_next = y - x_sh;
      z_next = z + atan_i;
    end
  end

endmodule

// File: rtl/cordic_vectoring.sv
// cordic_vectoring: iterative CORDIC vectoring engine returning magnitude and Q3.29 phase.
// Optional gain compensation (extra SCALE cycle, 1/K multiply) under `CORDIC_GAIN_COMP_EN.
module cordic_vectoring
  import cordic_pkg::*;
#(
  parameter int N    = 32,
  parameter int ITER = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic signed [N-1:0] x_in,
  input  logic signed [N-1:0] y_in,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [N:0]          mag_out,
  output logic signed [31:0]  phase_out
);

  localparam int         W    = N + 2;
  localparam logic [4:0] LAST = 5'(ITER - 1);

  state_t              state;
  logic signed [W-1:0] x_r;
  logic signed [W-1:0] y_r;
  logic signed [31:0]  z_r;
  logic [4:0]          iter;
  logic                zero_r;

  logic signed [W-1:0] x_ext;
  logic signed [W-1:0] y_ext;
  logic signed [W-1:0] x_pre;
  logic signed [W-1:0] y_pre;
  logic signed [31:0]  z_pre;
  logic signed [W-1:0] x_next;
  logic signed [W-1:0] y_next;
  logic signed [31:0]  z_next;

  // Quadrant pre-rotation folds x<0 into the right half-plane by +/-pi/2.
  always_comb begin
    x_ext = {{2{x_in[N-1]}}, x_in};
    y_ext = {{2{y_in[N-1]}}, y_in};
    x_pre = x_ext;
    y_pre = y_ext;
    z_pre = '0;
    if (x_ext[W-1]) begin
      if (!y_ext[W-1]) begin
        x_pre = y_ext;
        y_pre = -x_ext;
        z_pre = HALF_PI_Q329;
      end else begin
        x_pre = -y_ext;
        y_pre = x_ext;
        z_pre = -HALF_PI_Q329;
      end
    end
  end

  cordic_vec_stage #(
    .W(W)
  ) u_stage (
    .x      (x_r),
    .y      (y_r),
    .z      (z_r),
    .i      (iter),
    .atan_i (ATAN[iter]),
    .x_next (x_next),
    .y_next (y_next),
    .z_next (z_next)
  );

`ifdef CORDIC_GAIN_COMP_EN
  logic [W+31:0] prod_rnd;
  logic [N:0]    mag_scaled;

  // x is non-negative after the iterations, so an unsigned multiply is exact.
  always_comb begin
    prod_rnd   = (W+32)'($unsigned(x_r)) * (W+32)'(INV_K) + ((W+32)'(1) << 30);
    mag_scaled = (N+1)'(prod_rnd >> 31);
  end
`endif

  // A (0,0) input would otherwise accumulate the whole ATAN table into z.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      mag_out   <= '0;
      phase_out <= '0;
      x_r       <= '0;
      y_r       <= '0;
      z_r       <= '0;
      iter      <= '0;
      zero_r    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            x_r      <= x_pre;
            y_r      <= y_pre;
            z_r      <= z_pre;
            iter     <= '0;
            zero_r   <= (x_in == '0) && (y_in == '0);
            in_ready <= 1'b0;
            state    <= S_ITERATE;
          end
        end
        S_ITERATE: begin
          x_r  <= x_next;
          y_r  <= y_next;
          z_r  <= z_next;
          iter <= iter + 5'd1;
          if (iter == LAST) begin
`ifdef CORDIC_GAIN_COMP_EN
            state <= S_SCALE;
`else
            state     <= S_DONE;
            out_valid <= 1'b1;
            mag_out   <= x_next[N:0];
            phase_out <= zero_r ? '0 : z_next;
`endif
          end
        end
`ifdef CORDIC_GAIN_COMP_EN
        S_SCALE: begin
          state     <= S_DONE;
          out_valid <= 1'b1;
          mag_out   <= mag_scaled;
          phase_out <= zero_r ? '0 : z_r;
        end
`endif
        S_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cordic_vectoring.sv
// tb_cordic_vectoring: scoreboard bench; expected magnitude/phase come from real-valued
// sqrt/atan2 and the ideal CORDIC gain, popped by a monitor on each output handshake.
module tb_cordic_vectoring;

  localparam int  N    = 32;
  localparam int  ITER = 16;
  localparam real Q29  = 536870912.0;
  localparam real PI_Q = 1686629713.2;

  localparam logic signed [N-1:0] MINV = {1'b1, {(N-1){1'b0}}};

`ifdef CORDIC_GAIN_COMP_EN
  localparam int LAT = ITER + 2;
`else
  localparam int LAT = ITER + 1;
`endif

  logic                clk = 1'b0;
  logic                rst;
  logic                in_valid;
  logic                in_ready;
  logic signed [N-1:0] x_in;
  logic signed [N-1:0] y_in;
  logic                out_valid;
  logic                out_ready;
  logic [N:0]          mag_out;
  logic signed [31:0]  phase_out;

  always #5 clk = ~clk;

  cordic_vectoring #(
    .N    (N),
    .ITER (ITER)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x_in      (x_in),
    .y_in      (y_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .mag_out   (mag_out),
    .phase_out (phase_out)
  );

  typedef struct {
    real   mag;
    real   ph;
    real   mag_tol;
    real   ph_tol;
    string name;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;
  real  gain     = 1.0;

  task automatic check_int(input string name, input longint act, input longint want);
    checks++;
    if (act != want) begin
      failures++;
      $display("FAIL %s: got %0d want %0d", name, act, want);
    end
  endtask

  task automatic check_near(input string name, input real act, input real want, input real tol);
    checks++;
    if ((act - want > tol) || (want - act > tol)) begin
      failures++;
      $display("FAIL %s: got %0.1f want %0.1f (tol %0.1f)", name, act, want, tol);
    end
  endtask

  // Truncating shifts leave a few LSBs of residual y, worth about 4/|v| rad of phase.
  function automatic exp_t model(input longint x, input longint y, input string name);
    exp_t e;
    real  rx;
    real  ry;
    real  r;
    rx = real'(x);
    ry = real'(y);
    r  = $sqrt(rx * rx + ry * ry);
    e.name = name;
    if (x == 0 && y == 0) begin
      e.mag     = 0.0;
      e.ph      = 0.0;
      e.mag_tol = 0.0;
      e.ph_tol  = 0.0;
    end else begin
`ifdef CORDIC_GAIN_COMP_EN
      e.mag = r;
`else
      e.mag = r * gain;
`endif
      e.mag_tol = 2.0 + ITER;
      e.ph      = $atan2(ry, rx) * Q29;
      e.ph_tol  = 32768.0 + 4.0 * Q29 / r;
    end
    return e;
  endfunction

  initial begin : monitor
    exp_t e;
    real  act;
    real  want;
    forever begin
      @(negedge clk);
      if (!rst && out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check_int("unexpected_result", 1, 0);
        end else begin
          e = sb.pop_front();
          check_near({e.name, "_mag"}, real'(mag_out), e.mag, e.mag_tol);
          act  = real'(phase_out);
          want = e.ph;
          if (act - want > PI_Q) want = want + 2.0 * PI_Q;
          else if (want - act > PI_Q) want = want - 2.0 * PI_Q;
          check_near({e.name, "_phase"}, act, want, e.ph_tol);
        end
      end
    end
  end

  task automatic send(input logic signed [N-1:0] x, input logic signed [N-1:0] y, input string name);
    int n = 0;
    in_valid = 1'b1;
    x_in     = x;
    y_in     = y;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) check_int({name, "_accept_timeout"}, 0, 1);
    sb.push_back(model(x, y, name));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Latency counts the accept edge as cycle 1.
  task automatic wait_valid(output int lat);
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (sb.size() != 0 && n < 500) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 500) check_int({name, "_drain_timeout"}, sb.size(), 0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin : watchdog
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    int                  lat;
    logic [N:0]          mag_hold;
    logic signed [31:0]  ph_hold;
    logic                seen;
    logic signed [N-1:0] rx;
    logic signed [N-1:0] ry;

    for (int i = 0; i < ITER; i++) gain = gain * $sqrt(1.0 + 2.0 ** (-2.0 * i));

    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    x_in      = '0;
    y_in      = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check_int("reset_out_valid", out_valid, 0);
    check_int("reset_in_ready", in_ready, 1);
    check_int("reset_mag", mag_out, 0);
    check_int("reset_phase", phase_out, 0);
    @(posedge clk);
    #1;

    send(32'sd1000, 32'sd0, "x1000");
    wait_valid(lat);
    check_int("latency_x1000", lat, LAT);
    drain("x1000");

    send(32'sd1000, 32'sd1000, "diag");
    drain("diag");
    send(-32'sd1000, 32'sd0, "negx");
    drain("negx");
    send(32'sd0, -32'sd1000, "negy");
    drain("negy");
    send(32'sd0, 32'sd0, "zero");
    drain("zero");
    send(MINV, 32'sd0, "minx");
    send(32'sd2147483647, MINV, "maxx_miny");
    drain("edges");

    // Output held under back-pressure while a new vector waits at the input.
    out_ready = 1'b0;
    send(32'sd1000, 32'sd1000, "bp_vec");
    wait_valid(lat);
    check_int("bp_valid_seen", out_valid, 1);
    mag_hold = mag_out;
    ph_hold  = phase_out;
    in_valid = 1'b1;
    x_in     = 32'sd300;
    y_in     = -32'sd700;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check_int("bp_mag_stable", mag_out, mag_hold);
      check_int("bp_phase_stable", phase_out, ph_hold);
      check_int("bp_in_ready_low", in_ready, 0);
      check_int("bp_out_valid_high", out_valid, 1);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check_int("bp_in_ready_after_release", in_ready, 1);
    sb.push_back(model(300, -700, "bp_next"));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check_int("bp_next_accepted", in_ready, 0);
    drain("bp");

    // Abort the extreme vector mid-iteration.
    send(MINV, MINV, "abort");
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    sb.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    check_int("abort_out_valid", out_valid, 0);
    check_int("abort_in_ready", in_ready, 1);
    check_int("abort_mag", mag_out, 0);
    check_int("abort_phase", phase_out, 0);
    seen = 1'b0;
    repeat (ITER + 4) begin
      @(posedge clk);
      #1;
      if (out_valid) seen = 1'b1;
    end
    check_int("abort_no_result", seen, 0);
    send(MINV, MINV, "extreme");
    drain("extreme");

    for (int k = 0; k < 30; k++) begin
      rx = $urandom;
      ry = $urandom;
      send(rx, ry, $sformatf("rand_big%0d", k));
    end
    for (int k = 0; k < 12; k++) begin
      rx = N'($urandom_range(300, 2000));
      ry = N'($urandom_range(300, 2000));
      if ($urandom_range(0, 1) == 1) rx = -rx;
      if ($urandom_range(0, 1) == 1) ry = -ry;
      send(rx, ry, $sformatf("rand_small%0d", k));
    end
    drain("random");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
